// File: rtl/trace_capture_core.sv
// Circular trace buffer with pre-trigger window and mask/value or external trigger.
// Optional sample decimation is enabled by defining TRACE_DECIM_EN.
module trace_capture_core #(
    parameter int PROBE_W  = 17,
    parameter int DEPTH    = 256,
    parameter int PRE_TRIG = 64,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic               clk_i,
    input  logic               rst_i,
`ifdef TRACE_DECIM_EN
    input  logic [7:0]         decim_i,
`endif
    input  logic [PROBE_W-1:0] probe_i,
    input  logic               arm_i,
    input  logic               abort_i,
    input  logic               trig_src_i,
    input  logic               trig_edge_i,
    input  logic [PROBE_W-1:0] trig_mask_i,
    input  logic [PROBE_W-1:0] trig_value_i,
    input  logic               ext_trig_i,
    input  logic [AW-1:0]      rd_addr_i,
    output logic [PROBE_W-1:0] rd_data_o,
    output logic [2:0]         state_o,
    output logic               done_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_WAIT  = 3'd2,
        S_POST  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int          POST_N    = DEPTH - PRE_TRIG - 1;
    localparam logic [AW-1:0] PRE_LAST  = AW'(PRE_TRIG - 1);
    localparam logic [AW-1:0] POST_LAST = AW'(POST_N - 1);
    localparam logic [AW-1:0] PRE_OFS   = AW'(PRE_TRIG);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [PROBE_W-1:0]   r_mem [DEPTH];
    logic [AW-1:0]        r_wp;
    logic [AW-1:0]        r_pre_cnt;
    logic [AW-1:0]        r_post_cnt;
    logic [AW-1:0]        r_trig_addr;
    logic                 r_cond_prev;
    logic                 r_done;
    logic [PROBE_W-1:0]   r_rd_data;

    logic                 w_cond;
    logic                 w_hit;
    logic                 w_capt;
    logic                 w_strobe;
    logic                 w_we;
    logic                 w_arm_ok;
    logic [AW-1:0]        w_raddr;

    assign w_cond = trig_src_i ? ext_trig_i
                  : (((probe_i ^ trig_value_i) & trig_mask_i) == '0);
    assign w_hit  = trig_edge_i ? (w_cond & ~r_cond_prev) : w_cond;
    assign w_capt = (r_state == S_ARMED) || (r_state == S_WAIT)
                 || (r_state == S_POST);
    assign w_we   = w_capt && w_strobe;
    assign w_arm_ok = arm_i && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_raddr  = (r_trig_addr - PRE_OFS) + rd_addr_i;

`ifdef TRACE_DECIM_EN
    // Strobe phase restarts at zero on every entry into capture.
    logic [7:0] r_dcnt;
    assign w_strobe = (r_dcnt == 8'd0);
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_dcnt <= 8'd0;
        end else if (w_capt && !abort_i) begin
            r_dcnt <= (r_dcnt == decim_i) ? 8'd0 : r_dcnt + 8'd1;
        end else begin
            r_dcnt <= 8'd0;
        end
    end
`else
    assign w_strobe = 1'b1;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (arm_i) begin
                    w_state_nxt = (PRE_TRIG == 0) ? S_WAIT : S_ARMED;
                end
            end
            S_ARMED: begin
                if (w_strobe && r_pre_cnt == PRE_LAST) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_strobe && w_hit) begin
                    w_state_nxt = (POST_N == 0) ? S_DONE : S_POST;
                end
            end
            S_POST: begin
                if (w_strobe && r_post_cnt == POST_LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (abort_i) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_we) begin
            r_mem[r_wp] <= probe_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wp        <= '0;
            r_pre_cnt   <= '0;
            r_post_cnt  <= '0;
            r_trig_addr <= '0;
            r_cond_prev <= 1'b0;
            r_done      <= 1'b0;
            r_rd_data   <= '0;
        end else begin
            if (w_strobe) begin
                r_cond_prev <= w_cond;
            end
            if (w_we) begin
                r_wp <= r_wp + 1'b1;
            end
            if (r_state == S_ARMED && w_strobe) begin
                r_pre_cnt <= r_pre_cnt + 1'b1;
            end
            if (r_state == S_WAIT && w_strobe && w_hit) begin
                r_trig_addr <= r_wp;
                r_post_cnt  <= '0;
            end
            if (r_state == S_POST && w_strobe) begin
                r_post_cnt <= r_post_cnt + 1'b1;
            end
            if (w_arm_ok && !abort_i) begin
                r_pre_cnt <= '0;
                r_wp      <= '0;
            end
            r_done    <= (w_state_nxt == S_DONE);
            r_rd_data <= (r_state == S_DONE) ? r_mem[w_raddr] : '0;
        end
    end

    assign rd_data_o = r_rd_data;
    assign state_o   = r_state;
    assign done_o    = r_done;

endmodule

// File: tb/tb_trace_capture_core.sv
// Directed bench for trace_capture_core with PROBE_W=8, DEPTH=16, PRE_TRIG=4.
// Probe is a free-running counter advanced one step per clock.
module tb_trace_capture_core;

    localparam int PW = 8;
    localparam int DP = 16;
    localparam int PT = 4;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] exp;
    } rb_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [PW-1:0] probe = '0;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic          tsrc = 1'b0;
    logic          tedge = 1'b0;
    logic [PW-1:0] tmask = 8'hFF;
    logic [PW-1:0] tval = 8'h20;
    logic          ext = 1'b0;
    logic [3:0]    rd_addr = '0;
    logic [PW-1:0] rd_data;
    logic [2:0]    state;
    logic          done;

    int   n_tests = 0;
    int   n_fail = 0;
    logic [7:0] ctr = '0;
    logic       emode = 1'b0;
    logic       b0 = 1'b1;
    rb_t        tbl [16];

    trace_capture_core #(
        .PROBE_W(PW),
        .DEPTH(DP),
        .PRE_TRIG(PT)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
`ifdef TRACE_DECIM_EN
        .decim_i(8'd0),
`endif
        .probe_i(probe),
        .arm_i(arm),
        .abort_i(abort),
        .trig_src_i(tsrc),
        .trig_edge_i(tedge),
        .trig_mask_i(tmask),
        .trig_value_i(tval),
        .ext_trig_i(ext),
        .rd_addr_i(rd_addr),
        .rd_data_o(rd_data),
        .state_o(state),
        .done_o(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ctr++;
        probe = emode ? {ctr[6:0], b0} : ctr;
    endtask

    task automatic set_ctr(input logic [7:0] v);
        ctr   = v;
        probe = v;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (!done && n < max) begin
            tick();
            n++;
        end
        check("done_within_bound", {31'd0, done}, 32'd1);
    endtask

    task automatic readback(input string nm, input logic [7:0] base);
        for (int i = 0; i < DP; i++) begin
            rd_addr = i[3:0];
            tick();
            check(nm, {24'd0, rd_data}, {24'd0, base + i[7:0]});
        end
    endtask

    task automatic read_one(input logic [3:0] a, output logic [7:0] d);
        rd_addr = a;
        tick();
        d = rd_data;
    endtask

    initial begin
        int n;
        logic [7:0] d;
        logic [7:0] v0;
        logic [7:0] v1;
        logic [7:0] v2;

        for (int i = 0; i < 16; i++) begin
            tbl[i].addr = i[3:0];
            tbl[i].exp  = 8'h1C + i[7:0];
        end

        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_state", {29'd0, state}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_rd_data", {24'd0, rd_data}, 32'd0);

        // Internal level trigger at 0x20
        set_ctr(8'h10);
        do_arm();
        check("armed_state", {29'd0, state}, 32'd1);
        wait_done(100, n);
        check("done_latency", n, 32'd27);
        check("done_state", {29'd0, state}, 32'd4);
        for (int i = 0; i < 16; i++) begin
            rd_addr = tbl[i].addr;
            tick();
            check("level_readback", {24'd0, rd_data}, {24'd0, tbl[i].exp});
        end
        read_one(4'd4, d);
        check("level_trig_idx4", {24'd0, d}, 32'h20);
        check("level_state_done", {29'd0, state}, 32'd4);

        // Hit during pre-fill is ignored; trigger after counter wraps
        set_ctr(8'h1E);
        do_arm();
        while (ctr != 8'h30) tick();
        check("prefill_hit_ignored", {29'd0, state}, 32'd2);
        check("prefill_not_done", {31'd0, done}, 32'd0);
        wait_done(400, n);
        readback("prefill_readback", 8'h1C);

        // Edge mode on bit0
        tmask = 8'h01;
        tval  = 8'h01;
        tedge = 1'b1;
        emode = 1'b1;
        b0    = 1'b1;
        set_ctr(8'h00);
        probe = {ctr[6:0], b0};
        repeat (3) tick();
        do_arm();
        repeat (30) tick();
        check("edge_held_no_trig", {29'd0, state}, 32'd2);
        b0 = 1'b0;
        probe = {ctr[6:0], b0};
        v0 = probe;
        b0 = 1'b1;
        tick();
        v1 = probe;
        v2 = {v1[7:1] + 7'd1, 1'b1};
        tick();
        check("edge_post_state", {29'd0, state}, 32'd3);
        wait_done(40, n);
        read_one(4'd3, d);
        check("edge_idx3", {24'd0, d}, {24'd0, v0});
        read_one(4'd4, d);
        check("edge_idx4", {24'd0, d}, {24'd0, v1});
        read_one(4'd5, d);
        check("edge_idx5", {24'd0, d}, {24'd0, v2});
        emode = 1'b0;
        tedge = 1'b0;

        // External trigger pulse at counter 0x55
        tsrc = 1'b1;
        ext  = 1'b0;
        set_ctr(8'h40);
        do_arm();
        n = 0;
        while (ctr != 8'h55 && n < 100) begin
            tick();
            n++;
        end
        ext = 1'b1;
        tick();
        ext = 1'b0;
        wait_done(40, n);
        read_one(4'd4, d);
        check("ext_idx4", {24'd0, d}, 32'h55);
        read_one(4'd0, d);
        check("ext_idx0", {24'd0, d}, 32'h51);
        read_one(4'd15, d);
        check("ext_idx15", {24'd0, d}, 32'h60);
        tsrc = 1'b0;

        // Abort and arm together during POST
        tmask = 8'hFF;
        tval  = 8'h20;
        set_ctr(8'h10);
        do_arm();
        n = 0;
        while (state != 3'd3 && n < 100) begin
            tick();
            n++;
        end
        tick();
        tick();
        check("abort_pre_post", {29'd0, state}, 32'd3);
        abort = 1'b1;
        arm   = 1'b1;
        tick();
        abort = 1'b0;
        arm   = 1'b0;
        check("abort_state", {29'd0, state}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_rd_data", {24'd0, rd_data}, 32'd0);
        repeat (3) tick();
        check("abort_stays_idle", {29'd0, state}, 32'd0);
        tval = 8'h70;
        set_ctr(8'h60);
        do_arm();
        wait_done(100, n);
        readback("after_abort_readback", 8'h6C);

        // Synchronous reset during WAIT
        tval = 8'hF0;
        set_ctr(8'h80);
        do_arm();
        repeat (10) tick();
        check("rst_pre_wait", {29'd0, state}, 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_state", {29'd0, state}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_rd_data", {24'd0, rd_data}, 32'd0);
        tval = 8'hA0;
        set_ctr(8'h90);
        do_arm();
        check("rearm_state", {29'd0, state}, 32'd1);
        wait_done(100, n);
        check("rearm_latency", n, 32'd27);
        readback("after_rst_readback", 8'h9C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
